sar_logic_cf_param: RTL

- Parametrised coarse/fine split-capacitor SAR controller, N-bit resolution.
- The first K bit decisions use the coarse comparator and coarse DAC array; the remaining N-K decisions use the fine comparator and fine DAC array.
- New relative to the fixed 10-bit/k=7 controller:
  - guaranteed minimum track (sample) time;
  - pending-start latch;
  - continuous-conversion mode;
  - registered result with `dvalid`/`busy`;
  - overrun flag.
- Sits between the bootstrap sampler, the two comparators and the capacitor-array switch drivers.

---
 rtl/sar_cf_pkg.sv | 37 +++
 rtl/sar_start_ctrl.sv | 46 ++++
 rtl/sar_logic_cf_param.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/sar_cf_pkg.sv
// Shared types and elaboration helpers for the coarse/fine SAR controller.
package sar_cf_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_C_DRAIN,
    S_C_LOAD,
    S_C_CMP,
    S_C_DEC,
    S_F_DRAIN,
    S_F_LOAD,
    S_F_CMP,
    S_F_DEC,
    S_DONE
  } state_t;

  // Bits needed to index v entries, never less than one.
  function automatic int cw(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  // Index width for the N-bit working register.
  function automatic int bw_of_n(input int n);
    return cw(n);
  endfunction

  // Index width for the K coarse decisions.
  function automatic int bw_of_k(input int k);
    return cw(k);
  endfunction

  // Coarse array preload: upper k switches on, lower k off.
  function automatic logic [63:0] coarse_preload(input int k);
    return ((64'd1 << k) - 64'd1) << k;
  endfunction

endpackage

// File: rtl/sar_start_ctrl.sv
// Track-time counter, pending-start latch, start qualification and overrun flag.
module sar_start_ctrl
  import sar_cf_pkg::*;
#(
  parameter int T_TRACK = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_idle,
  input  logic busy,
  input  logic cnvst,
  input  logic cont,
  output logic start,
  output logic ovr
);

  localparam int TW = cw(T_TRACK);
  localparam logic [TW-1:0] TRK_LAST = TW'(T_TRACK - 1);

  logic [TW-1:0] trk_cnt;
  logic          pend;
  logic          trk_done;

  assign trk_done = (trk_cnt == TRK_LAST);
  assign start    = in_idle && trk_done && (cnvst || pend || cont);

  // Track counter saturates in IDLE and restarts from zero on every IDLE entry;
  // a request is only latched while idle, requests during a conversion flag overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_cnt <= '0;
      pend    <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      ovr <= busy & cnvst;
      if (!in_idle) begin
        trk_cnt <= '0;
        pend    <= 1'b0;
      end else begin
        if (!trk_done) trk_cnt <= trk_cnt + TW'(1);
        pend <= start ? 1'b0 : (pend | cnvst);
      end
    end
  end

endmodule

// File: rtl/sar_logic_cf_param.sv
// Coarse/fine split-capacitor SAR controller: K coarse decisions, N-K fine decisions.
//
// state     | meaning
// ----------+---------------------------------------------------
// S_IDLE    | tracking (s_clk=1), wait for track time + request
// S_C_DRAIN | open coarse drain switch
// S_C_LOAD  | preload coarse array, init bit pointers
// S_C_CMP   | fire coarse comparator clock
// S_C_DEC   | take coarse decision for bit b
// S_F_DRAIN | open fine drain switch
// S_F_LOAD  | transfer coarse result onto fine array
// S_F_CMP   | fire fine comparator clock
// S_F_DEC   | take fine decision for bit b
// S_DONE    | result registered, eoc/dvalid high
module sar_logic_cf_param
  import sar_cf_pkg::*;
#(
  parameter int N       = 10,
  parameter int K       = 7,
  parameter int T_TRACK = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cnvst,
  input  logic           cont,
  input  logic           cmp_out,
  input  logic           cmp_out_coarse,
  output logic [N-1:0]   sar,
  output logic [N-1:0]   dout,
  output logic           dvalid,
  output logic           eoc,
  output logic           busy,
  output logic           ovr,
  output logic           cmp_clk,
  output logic           cmp_clk_coarse,
  output logic           s_clk,
  output logic [2*N-1:0] fine_btm,
  output logic [2*K-1:0] coarse_btm,
  output logic           fine_switch_drain,
  output logic           coarse_switch_drain,
  output logic           s_clk_not,
  output logic [2*N-1:0] fine_btm_not,
  output logic [2*K-1:0] coarse_btm_not,
  output logic           fine_switch_drain_not,
  output logic           coarse_switch_drain_not
);

  localparam int BW  = bw_of_n(N);
  localparam int KW  = bw_of_k(K);
  localparam int FW  = cw(2 * N);
  localparam int CBW = cw(2 * K);
  localparam logic [63:0] C_PRE64 = coarse_preload(K);

  generate
    if (N < 2 || K < 1 || K > N - 1 || T_TRACK < 1) begin : g_bad_param
      $error("sar_logic_cf_param: illegal N/K/T_TRACK combination");
    end
  endgenerate

  state_t          state, state_nxt;
  logic [BW-1:0]   b, b_m1;
  logic [KW-1:0]   bc;
  logic [FW-1:0]   fi_lo, fi_up;
  logic [CBW-1:0]  ci_lo, ci_up;
  logic            start, in_idle;

  assign in_idle = (state == S_IDLE);
  assign b_m1    = b - BW'(1);
  assign fi_lo   = FW'(b);
  assign fi_up   = FW'(b) + FW'(N);
  assign ci_lo   = CBW'(bc);
  assign ci_up   = CBW'(bc) + CBW'(K);

  sar_start_ctrl #(.T_TRACK(T_TRACK)) u_start (
    .clk     (clk),
    .rst     (rst),
    .in_idle (in_idle),
    .busy    (busy),
    .cnvst   (cnvst),
    .cont    (cont),
    .start   (start),
    .ovr     (ovr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; decision loops exit on the pointer value used for the decision.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_C_DRAIN;
      S_C_DRAIN: state_nxt = S_C_LOAD;
      S_C_LOAD:  state_nxt = S_C_CMP;
      S_C_CMP:   state_nxt = S_C_DEC;
      S_C_DEC:   state_nxt = (bc != '0) ? S_C_CMP : S_F_DRAIN;
      S_F_DRAIN: state_nxt = S_F_LOAD;
      S_F_LOAD:  state_nxt = S_F_CMP;
      S_F_CMP:   state_nxt = S_F_DEC;
      S_F_DEC:   state_nxt = (b != '0) ? S_F_CMP : S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Registered datapath and switch drivers, updated from the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sar                 <= '0;
      dout                <= '0;
      dvalid              <= 1'b0;
      eoc                 <= 1'b0;
      busy                <= 1'b0;
      cmp_clk             <= 1'b0;
      cmp_clk_coarse      <= 1'b0;
      fine_btm            <= '0;
      coarse_btm          <= '0;
      fine_switch_drain   <= 1'b1;
      coarse_switch_drain <= 1'b1;
      b                   <= '0;
      bc                  <= '0;
    end else begin
      cmp_clk        <= 1'b0;
      cmp_clk_coarse <= 1'b0;
      dvalid         <= 1'b0;
      eoc            <= 1'b0;
      busy           <= (state_nxt != S_IDLE);
      case (state)
        S_IDLE: begin
          sar                 <= '0;
          sar[N-1]            <= 1'b1;
          fine_btm            <= '0;
          coarse_btm          <= '0;
          fine_switch_drain   <= 1'b1;
          coarse_switch_drain <= 1'b1;
        end
        S_C_DRAIN: coarse_switch_drain <= 1'b0;
        S_C_LOAD: begin
          coarse_btm <= C_PRE64[2*K-1:0];
          b          <= BW'(N - 1);
          bc         <= KW'(K - 1);
        end
        S_C_CMP: cmp_clk_coarse <= 1'b1;
        S_C_DEC: begin
          sar[b] <= cmp_out_coarse;
          if (cmp_out_coarse) coarse_btm[ci_lo] <= 1'b1;
          else                coarse_btm[ci_up] <= 1'b0;
          sar[b_m1] <= 1'b1;
          b         <= b_m1;
          bc        <= bc - KW'(1);
        end
        S_F_DRAIN: fine_switch_drain <= 1'b0;
        S_F_LOAD: begin
          for (int i = N - K; i < N; i++) begin
            if (sar[i]) begin
              fine_btm[i+N] <= 1'b1;
              fine_btm[i]   <= 1'b1;
            end
          end
          fine_btm[2*N-K-1:N] <= '1;
        end
        S_F_CMP: cmp_clk <= 1'b1;
        S_F_DEC: begin
          sar[b] <= cmp_out;
          if (cmp_out) fine_btm[fi_lo] <= 1'b1;
          else         fine_btm[fi_up] <= 1'b0;
          if (b != '0) begin
            sar[b_m1] <= 1'b1;
            b         <= b_m1;
          end else begin
            dout   <= {sar[N-1:1], cmp_out};
            dvalid <= 1'b1;
            eoc    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_clk                   = rst | in_idle;
  assign s_clk_not               = ~s_clk;
  assign fine_btm_not            = ~fine_btm;
  assign coarse_btm_not          = ~coarse_btm;
  assign fine_switch_drain_not   = ~fine_switch_drain;
  assign coarse_switch_drain_not = ~coarse_switch_drain;

endmodule
